defuzz_wavg: RTL and testbench
==============================

// Module: defuzz_wavg
// PURPOSE
//  Weighted-average (singleton centroid) defuzzifier; inverse of the fuzzification front end.
//  Takes N rule firing strengths mu_i (Q1.15, as produced by the MF evaluators/rule stage)
//  and N signed output singleton positions s_i (Q7.0); returns crisp y = sum(mu_i*s_i)/sum(mu_i) in Q7.0.
//  Multi-cycle: one MAC per cycle, then a serial restoring divider; valid/ready on both sides.
// PARAMETERS
//  N_RULES  4   number of rules/singletons (>=2)
//  MU_W     16  strength width, unsigned Q1.15 (0x0000..0x7FFF)
//  POS_W    8   singleton/output width, signed Q7.0
// PORTS
//  clk        in   1              clock, all logic on rising edge
//  rst        in   1              synchronous reset, active-high
//  in_valid   in   1              mu_flat/pos_flat valid
//  in_ready   out  1              block can accept a job
//  mu_flat    in   N_RULES*MU_W   rule i strength at [i*MU_W +: MU_W], unsigned
//  pos_flat   in   N_RULES*POS_W  rule i singleton at [i*POS_W +: POS_W], signed
//  out_valid  out  1              y/y_none valid
//  out_ready  in   1              consumer accepts result
//  y          out  POS_W          crisp output, signed Q7.0
//  y_none     out  1              1 = all strengths zero (no rule fired); y forced to 0
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, y=0, y_none=0; num, den, idx, quotient cleared.
//   rst has priority in every state; mid-job reset aborts and discards the job, no output produced.
//  FSM IDLE -> ACC -> DIV -> DONE -> IDLE; in_ready=1 only in IDLE; no job overlap.
//  IDLE: on in_valid&in_ready capture mu_flat/pos_flat into regs, num=0, den=0, idx=0 -> ACC.
//  ACC: per cycle num += $signed({1'b0,mu_idx}) * $signed(pos_idx); den += mu_idx; idx++.
//   Widths: product MU_W+POS_W+1 signed; num adds $clog2(N_RULES) guard bits; den MU_W+$clog2(N_RULES).
//   No overflow possible at these widths. After rule N_RULES-1: den!=0 -> DIV; den==0 -> DONE, y=0, y_none=1.
//  DIV: sign = num[MSB]; divide |num| by den, restoring, POS_W iterations MSB-first (one quotient bit/cycle).
//   Quotient magnitude <= 2^(POS_W-1); truncate toward zero; apply sign; clamp to [-128,+127].
//   mu scaling cancels: quotient is directly Q7.0. Then -> DONE with y_none=0.
//  Latency: accepting edge = E0; ACC occupies edges E1..EN; DIV E(N+1)..E(N+8); out_valid=1 after E(N+8)
//   (N+8 cycles; N=4 -> 12). Zero-strength case: out_valid=1 after EN.
//  DONE: out_valid=1, y/y_none stable, in_valid ignored; on out_valid&out_ready -> IDLE (in_ready=1 next cycle).
//   out_ready held low -> wait indefinitely, outputs frozen.
//  y/y_none hold last result after handshake until the next DONE (or rst).
//  Input regs are captured; mu_flat/pos_flat may change after acceptance without effect.
//  mu values above 0x7FFF are not produced upstream; treated as plain unsigned if present.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> in_ready=1, out_valid=0, y=0, y_none=0.
//  T2 single rule: mu={7FFF,0,0,0}, pos={40,0,0,0} -> y=40, y_none=0, out_valid exactly 12 cycles after accept.
//  T3 two rules: mu={4000,4000,0,0}, pos={-20,60,0,0} -> y=20.
//  T4 negative truncation: mu={4000,2000,0,0}, pos={-10,0,0,0} (-163840/24576=-6.67) -> y=-6; extremes
//   mu all 7FFF, pos all -128 -> y=-128; pos all 127 -> y=127.
//  T5 no firing: mu all 0 -> y=0, y_none=1, out_valid 4 cycles after accept.
//  T6 control: out_ready low 5 cycles in DONE -> y stable, in_ready=0, in_valid pulses ignored;
//   rst during ACC -> IDLE next cycle, no out_valid; back-to-back jobs produce both results in order.

Source files
------------

// File: rtl/defuzz_wavg.sv
// Weighted-average (singleton centroid) defuzzifier.
// Computes y = sum(mu_i * s_i) / sum(mu_i) using one multiply-accumulate per
// cycle, then a serial restoring divider that produces one quotient bit per cycle.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  job handshake; mu_flat (unsigned Q1.15) and pos_flat (signed Q7.0)
//   out_valid/out_ready result handshake; y is signed Q7.0
//   y_none             1 when every strength is zero (y is then forced to 0)
module defuzz_wavg #(
    parameter int unsigned N_RULES = 4,
    parameter int unsigned MU_W    = 16,
    parameter int unsigned POS_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_RULES*MU_W-1:0]     mu_flat,
    input  logic [N_RULES*POS_W-1:0]    pos_flat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [POS_W-1:0]     y,
    output logic                        y_none
);

    localparam int unsigned IDX_W  = (N_RULES > 1) ? $clog2(N_RULES) : 1;
    localparam int unsigned PROD_W = MU_W + POS_W + 1;
    localparam int unsigned NUM_W  = PROD_W + IDX_W;
    localparam int unsigned DEN_W  = MU_W + IDX_W;
    localparam int unsigned REM_W  = DEN_W + 1;
    localparam int unsigned CNT_W  = (POS_W > 1) ? $clog2(POS_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV, S_DONE} state_t;

    state_t                      r_state, w_state_nxt;
    logic [N_RULES*MU_W-1:0]     r_mu;
    logic [N_RULES*POS_W-1:0]    r_pos;
    logic signed [NUM_W-1:0]     r_num;
    logic [DEN_W-1:0]            r_den;
    logic [IDX_W-1:0]            r_idx;
    logic                        r_neg;
    logic [REM_W-1:0]            r_rem;
    logic [POS_W-1:0]            r_dvd;
    logic [POS_W-1:0]            r_quo;
    logic [CNT_W-1:0]            r_cnt;

    logic [MU_W-1:0]             w_mu_arr [N_RULES];
    logic signed [POS_W-1:0]     w_pos_arr [N_RULES];
    logic [MU_W-1:0]             w_mu;
    logic signed [POS_W-1:0]     w_pos;
    logic signed [PROD_W-1:0]    w_mu_ext, w_pos_ext, w_prod;
    logic signed [NUM_W-1:0]     w_num_nxt;
    logic [DEN_W-1:0]            w_den_nxt;
    logic [NUM_W-1:0]            w_abs;
    logic                        w_last;
    logic [REM_W-1:0]            w_trial, w_rem_nxt;
    logic                        w_ge;
    logic [POS_W-1:0]            w_q_nxt;
    logic signed [POS_W-1:0]     w_y;

    // Unpack the captured job into per-rule arrays.
    always_comb begin
        for (int i = 0; i < N_RULES; i++) begin
            w_mu_arr[i]  = r_mu[i*MU_W +: MU_W];
            w_pos_arr[i] = r_pos[i*POS_W +: POS_W];
        end
    end

    // Accumulator datapath: mu is zero-extended so the product stays signed.
    always_comb begin
        w_mu      = w_mu_arr[r_idx];
        w_pos     = w_pos_arr[r_idx];
        w_mu_ext  = PROD_W'({1'b0, w_mu});
        w_pos_ext = PROD_W'(w_pos);
        w_prod    = w_mu_ext * w_pos_ext;
        w_num_nxt = r_num + NUM_W'(w_prod);
        w_den_nxt = r_den + DEN_W'(w_mu);
        w_last    = (r_idx == IDX_W'(N_RULES - 1));
        w_abs     = w_num_nxt[NUM_W-1] ? NUM_W'(-w_num_nxt) : NUM_W'(w_num_nxt);
    end

    // Restoring divider step. The quotient fits in POS_W bits, so the bits of
    // |num| above POS_W are preloaded as the initial remainder (always < den).
    always_comb begin
        w_trial   = {r_rem[REM_W-2:0], r_dvd[POS_W-1]};
        w_ge      = (w_trial >= {1'b0, r_den});
        w_rem_nxt = w_ge ? (w_trial - {1'b0, r_den}) : w_trial;
        w_q_nxt   = {r_quo[POS_W-2:0], w_ge};
        // Negative magnitude up to 2^(POS_W-1) is representable; positive clamps.
        if (r_neg) begin
            w_y = $signed(-w_q_nxt);
        end else if (w_q_nxt[POS_W-1]) begin
            w_y = $signed({1'b0, {(POS_W-1){1'b1}}});
        end else begin
            w_y = $signed(w_q_nxt);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_state_nxt = S_ACC;
            S_ACC:  if (w_last)    w_state_nxt = (w_den_nxt != '0) ? S_DIV : S_DONE;
            S_DIV:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mu   <= '0;
            r_pos  <= '0;
            r_num  <= '0;
            r_den  <= '0;
            r_idx  <= '0;
            r_neg  <= 1'b0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            y      <= '0;
            y_none <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mu  <= mu_flat;
                        r_pos <= pos_flat;
                        r_num <= '0;
                        r_den <= '0;
                        r_idx <= '0;
                    end
                end
                S_ACC: begin
                    r_num <= w_num_nxt;
                    r_den <= w_den_nxt;
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        if (w_den_nxt == '0) begin
                            y      <= '0;
                            y_none <= 1'b1;
                        end else begin
                            r_neg <= w_num_nxt[NUM_W-1];
                            r_rem <= REM_W'(w_abs >> POS_W);
                            r_dvd <= w_abs[POS_W-1:0];
                            r_quo <= '0;
                            r_cnt <= CNT_W'(POS_W - 1);
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[POS_W-2:0], 1'b0};
                    r_quo <= w_q_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        y      <= w_y;
                        y_none <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_defuzz_wavg.sv
// Self-checking bench for defuzz_wavg: directed vector table, control-path
// sequences, and random jobs against an arithmetic reference model.
module tb_defuzz_wavg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] mu_flat;
    logic [31:0] pos_flat;
    logic        out_valid;
    logic        out_ready;
    logic signed [7:0] y;
    logic        y_none;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    defuzz_wavg #(.N_RULES(4), .MU_W(16), .POS_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mu_flat   (mu_flat),
        .pos_flat  (pos_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_none    (y_none)
    );

    typedef struct {
        logic [63:0] mu;
        logic [31:0] pos;
        int          ey;
        int          en;
        int          lat;
    } vec_t;

    function automatic logic [63:0] pk_mu(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [31:0] pk_pos(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Reference: exact weighted average, integer division truncates toward zero.
    task automatic ref_model(input logic [63:0] m, input logic [31:0] p,
                             output int ey, output int en, output int lat);
        longint num = 0;
        longint den = 0;
        longint q;
        for (int i = 0; i < 4; i++) begin
            logic [15:0]       mu_i  = m[i*16 +: 16];
            logic signed [7:0] pos_i = p[i*8 +: 8];
            num += longint'(mu_i) * longint'(pos_i);
            den += longint'(mu_i);
        end
        if (den == 0) begin
            ey = 0; en = 1; lat = 4;
        end else begin
            q = num / den;
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
            ey = int'(q); en = 0; lat = 12;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [63:0] m, input logic [31:0] p, input string tag);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " in_ready"}, int'(in_ready), 1);
        mu_flat  = m;
        pos_flat = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mu_flat  = {$urandom, $urandom};
        pos_flat = $urandom;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 100) begin
            if (out_valid) seen = 1;
            else begin
                @(posedge clk); #1; n++;
            end
        end
        lat = seen ? n : -1;
    endtask

    task automatic run_job(input logic [63:0] m, input logic [31:0] p,
                           input int ey, input int en, input int elat, input string tag);
        int lat;
        start_job(m, p, tag);
        wait_done(lat);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " y"}, int'(y), ey);
        chk({tag, " y_none"}, int'(y_none), en);
        @(posedge clk); #1;
        chk({tag, " out_valid after hs"}, int'(out_valid), 0);
        chk({tag, " y hold"}, int'(y), ey);
    endtask

    vec_t tbl[8];

    initial begin
        int lat, cnt, ey, en, el;
        logic [63:0] m;
        logic [31:0] p;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mu_flat = '0; pos_flat = '0;

        // T1 reset
        @(posedge clk); @(posedge clk); #1;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset y", int'(y), 0);
        chk("reset y_none", int'(y_none), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        tbl[0] = '{pk_mu('h7FFF, 0, 0, 0),            pk_pos(40, 0, 0, 0),            40,   0, 12};
        tbl[1] = '{pk_mu('h4000, 'h4000, 0, 0),       pk_pos(-20, 60, 0, 0),          20,   0, 12};
        tbl[2] = '{pk_mu('h4000, 'h2000, 0, 0),       pk_pos(-10, 0, 0, 0),           -6,   0, 12};
        tbl[3] = '{pk_mu('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF), pk_pos(-128, -128, -128, -128), -128, 0, 12};
        tbl[4] = '{pk_mu('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF), pk_pos(127, 127, 127, 127),  127,  0, 12};
        tbl[5] = '{pk_mu(0, 0, 0, 0),                  pk_pos(55, -3, 9, 100),         0,    1, 4};
        tbl[6] = '{pk_mu('h7FFF, 1, 0, 0),             pk_pos(100, -100, 0, 0),        99,   0, 12};
        tbl[7] = '{pk_mu(1, 1, 1, 1),                  pk_pos(-1, -2, 0, 0),           0,    0, 12};

        // T2..T5 directed table
        for (int i = 0; i < 8; i++)
            run_job(tbl[i].mu, tbl[i].pos, tbl[i].ey, tbl[i].en, tbl[i].lat,
                    $sformatf("vec%0d", i));

        // T6a out_ready held low in DONE: outputs frozen, new jobs ignored
        out_ready = 1'b0;
        start_job(tbl[1].mu, tbl[1].pos, "stall");
        wait_done(lat);
        chk("stall latency", lat, 12);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            mu_flat  = pk_mu('h7FFF, 0, 0, 0);
            pos_flat = pk_pos(-77, 0, 0, 0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d out_valid", k), int'(out_valid), 1);
            chk($sformatf("stall%0d in_ready", k), int'(in_ready), 0);
            chk($sformatf("stall%0d y", k), int'(y), 20);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall release out_valid", int'(out_valid), 0);
        chk("stall release in_ready", int'(in_ready), 1);
        chk("stall release y hold", int'(y), 20);

        // T6b reset during ACC aborts the job
        start_job(tbl[0].mu, tbl[0].pos, "abort");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort in_ready", int'(in_ready), 1);
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort y", int'(y), 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("abort no output", cnt, 0);

        // T6c back-to-back jobs
        run_job(tbl[2].mu, tbl[2].pos, -6, 0, 12, "b2b0");
        run_job(tbl[1].mu, tbl[1].pos, 20, 0, 12, "b2b1");

        // Random jobs against the reference model
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < 4; i++) begin
                m[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(0, 32767));
                p[i*8 +: 8]   = 8'($urandom);
            end
            if (j % 10 == 9) m = '0;
            ref_model(m, p, ey, en, el);
            run_job(m, p, ey, en, el, $sformatf("rnd%0d", j));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
